rx_engine: RTL and testbench
============================

Name: rx_engine

Overview:
UART receive engine; the downstream counterpart of the transmit engine. Samples the serial line and checks the frame format using the same runtime controls as the transmitter: baud, eight, p_en, ohel. Presents the received byte, status flags and a ready strobe to the TramelBlaze port logic. Sits between the board rx pin and the processor's IN_PORT / interrupt path (through the PED / SR-flop pair).

Parameters:
SYNC_STAGES, 2, flip-flop depth of the rx input synchronizer (min 2)
CLK_HZ, 100000000, system clock; baud count table is computed from it in the package

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rx  in  1  serial input, idle high, asynchronous to clk
baud  in  4  baud select: 0=300, 1=1200, 2=2400, 3=4800, 4=9600, 5=19200, 6=38400, 7=57600, 8=115200, 9=230400, A=460800, B=921600, C-F=115200
eight  in  1  1 = 8 data bits, 0 = 7 data bits
p_en  in  1  parity bit present and checked
ohel  in  1  1 = odd parity, 0 = even parity
read  in  1  one-cycle pulse; processor has consumed data/status
data  out  8  received byte, LSB first on the line; bit7 = 0 in 7-bit mode
rxrdy  out  1  new byte available, sticky until read
perr  out  1  parity error on the byte in data
ferr  out  1  framing error: stop bit sampled low
ovf  out  1  overrun: a frame completed while rxrdy was still 1

Behaviour:
- Reset (rst low, async): state IDLE, all counters 0, data=0, rxrdy=0, perr=0, ferr=0, ovf=0, synchronizer flops set to 1.
- Synchronizer: rx passes through SYNC_STAGES flops. All logic uses the synchronized value rxs.
- Bit period: N = BAUD_CNT[baud]; half period H = N/2, truncated.
- baud, eight, p_en and ohel are sampled into shadow registers on the start edge. Changes mid-frame do not affect the current frame.
- States:
  - IDLE: wait for rxs = 0. Then clear the bit counter, load the timer with H, go to START.
  - START: at timer expiry, if rxs = 1 the start was false: go to IDLE, no flags change. Otherwise load N and go to DATA.
  - DATA: sample at each expiry and shift right into the shift register. Sample count is 7 or 8 data bits, plus 1 parity bit if p_en. After the last sample, load N and go to STOP.
  - STOP: at expiry, sample the stop bit, update outputs, go to IDLE. IDLE rearms immediately; a start edge in the next cycle is accepted.
- Output update (registered, the cycle after the stop-bit sample):
  - data = received bits; bit7 forced 0 when eight = 0.
  - perr = p_en & (parity_bit != (^data_bits ^ ohel)).
  - ferr = ~stop_bit.
  - ovf = rxrdy_prev & ~read. ovf is sticky until read.
  - rxrdy = 1.
- read: clears rxrdy, perr, ferr and ovf on the next edge.
  - read in the same cycle as an output update: the update wins. rxrdy = 1, new perr/ferr, ovf = 0.
  - read while rxrdy = 0: no effect.
- Line held low (break): produces data = 0 and ferr = 1 once, then IDLE waits for rxs = 1 before re-arming. No repeated frames.
- Timer: down-counter, 19 bits, covers the 300-baud count of 333333. Expiry is count == 0. The counter reloads on expiry; there is no wrap-around.

Optional Feature:
RX_MAJORITY_EN: when defined, each start/data/parity/stop sample is the 2-of-3 majority of rxs at expiry-16, expiry-8 and expiry clocks. This rejects glitches shorter than 8 clocks. When undefined, a single sample is taken at expiry. Frame timing and flag rules are identical either way.

Decomposition:
- Shared package uart_pkg:
  - BAUD_CNT[16] lookup function derived from CLK_HZ
  - state enum {IDLE, START, DATA, STOP}
  - data-bit widths DBITS_7 / DBITS_8
  - timer width constant
  The transmit engine uses the same package.
- One sub-module, rx_bit_timer: loadable down-counter with an expiry pulse and, under RX_MAJORITY_EN, sample-tap pulses.

Test Plan:
1. baud=8, eight=1, p_en=0: send 0xA5 with stop=1 -> data=0xA5, rxrdy=1, perr=ferr=ovf=0, rxrdy rises about 9.5×868 clocks after the start edge.
2. baud=4, eight=0, p_en=1, ohel=1: send 0x41 with parity bit 1 -> data=0x41, perr=0. Repeat with parity bit 0 -> perr=1.
3. baud=8: send 0x3C with stop bit 0 -> ferr=1, data=0x3C. Pulse read -> rxrdy=ferr=0 next cycle.
4. Send 0x11 then 0x22 with no read -> data=0x22, ovf=1. Repeat with read coincident with the second update -> ovf=0, rxrdy=1.
5. 300-clock low glitch at baud=8 (< H=434) -> returns to IDLE, no flags. Reset asserted mid-frame -> all outputs 0 immediately; the next clean frame 0x5A is received correctly.
6. With RX_MAJORITY_EN defined: a 4-clock high glitch at the data-bit centre of 0x00 -> data=0x00. Without the macro, the same stimulus flips that bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive engines: baud divisor
// table, engine states, data-bit widths and timer width.
package uart_pkg;

  localparam int unsigned TIMER_W = 19;
  localparam int unsigned DBITS_7 = 7;
  localparam int unsigned DBITS_8 = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  typedef logic [15:0][TIMER_W-1:0] baud_tab_t;

  function automatic int unsigned baud_rate(input logic [3:0] sel);
    case (sel)
      4'h0:    return 300;
      4'h1:    return 1200;
      4'h2:    return 2400;
      4'h3:    return 4800;
      4'h4:    return 9600;
      4'h5:    return 19200;
      4'h6:    return 38400;
      4'h7:    return 57600;
      4'h8:    return 115200;
      4'h9:    return 230400;
      4'hA:    return 460800;
      4'hB:    return 921600;
      default: return 115200;
    endcase
  endfunction

  // Clocks per bit for every baud select code, folded to constants at elaboration.
  function automatic baud_tab_t baud_table(input int unsigned clk_hz);
    baud_tab_t tab;
    for (int i = 0; i < 16; i++) tab[i] = TIMER_W'(clk_hz / baud_rate(4'(i)));
    return tab;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Loadable bit-period down-counter with an expiry flag. With RX_MAJORITY_EN
// defined it also flags the points 16 and 8 clocks before expiry.
module rx_bit_timer
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
`ifdef RX_MAJORITY_EN
  ,
  output logic               tap16,
  output logic               tap8
`endif
);

  logic [TIMER_W-1:0] cnt_q;

  // Parks at zero when idle; only the engine's reload restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);

`ifdef RX_MAJORITY_EN
  assign tap16 = (cnt_q == TIMER_W'(16));
  assign tap8  = (cnt_q == TIMER_W'(8));
`endif

endmodule

// File: rtl/rx_engine.sv
// UART receive engine: synchronizes rx, frames start/data/parity/stop and
// presents data plus perr/ferr/ovf/rxrdy. Optional macro: RX_MAJORITY_EN.
module rx_engine
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CLK_HZ      = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       p_en,
  input  logic       ohel,
  input  logic       read,
  output logic [7:0] data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  localparam baud_tab_t   BAUD_CNT = baud_table(CLK_HZ);
  localparam int unsigned SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SYNC_N-1:0]  sync_q;
  logic               rxs;
  uart_state_e        state_q;
  logic [3:0]         baud_q;
  logic               eight_q, p_en_q, ohel_q;
  logic [3:0]         bit_cnt_q;
  logic [8:0]         sreg_q;
  logic               brk_wait_q;
  logic               tmr_load, expire, sample;
  logic [TIMER_W-1:0] tmr_val;
  logic [3:0]         nsamp, shamt;
  logic [8:0]         aligned;
  logic [7:0]         dbits;
  logic               par_bit, par_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_N-2:0], rx};
  end
  assign rxs = sync_q[SYNC_N-1];

`ifdef RX_MAJORITY_EN
  logic tap16, tap8, s16_q, s8_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s16_q <= 1'b1;
      s8_q  <= 1'b1;
    end else begin
      if (tap16) s16_q <= rxs;
      if (tap8)  s8_q  <= rxs;
    end
  end
  assign sample = (s16_q & s8_q) | (s16_q & rxs) | (s8_q & rxs);
`else
  assign sample = rxs;
`endif

  rx_bit_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
`ifdef RX_MAJORITY_EN
    ,
    .tap16    (tap16),
    .tap8     (tap8)
`endif
  );

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = BAUD_CNT[baud_q];
    case (state_q)
      IDLE: begin
        if (!brk_wait_q && !rxs) begin
          tmr_load = 1'b1;
          tmr_val  = BAUD_CNT[baud] >> 1;
        end
      end
      START:   tmr_load = expire & ~sample;
      DATA:    tmr_load = expire;
      default: tmr_load = 1'b0;
    endcase
  end

  // Samples enter at bit 8 and shift right, so the frame ends up left-aligned.
  always_comb begin
    nsamp   = (eight_q ? 4'(DBITS_8) : 4'(DBITS_7)) + {3'b000, p_en_q};
    shamt   = 4'd9 - nsamp;
    aligned = sreg_q >> shamt;
    dbits   = aligned[7:0] & (eight_q ? 8'hFF : 8'h7F);
    par_bit = eight_q ? aligned[8] : aligned[7];
    par_err = p_en_q & (par_bit != (^dbits ^ ohel_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      eight_q    <= 1'b0;
      p_en_q     <= 1'b0;
      ohel_q     <= 1'b0;
      bit_cnt_q  <= '0;
      sreg_q     <= '0;
      brk_wait_q <= 1'b0;
      data       <= '0;
      rxrdy      <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (read) begin
        rxrdy <= 1'b0;
        perr  <= 1'b0;
        ferr  <= 1'b0;
        ovf   <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (brk_wait_q) begin
            if (rxs) brk_wait_q <= 1'b0;
          end else if (!rxs) begin
            bit_cnt_q <= '0;
            baud_q    <= baud;
            eight_q   <= eight;
            p_en_q    <= p_en;
            ohel_q    <= ohel;
            state_q   <= START;
          end
        end
        START: begin
          if (expire) state_q <= sample ? IDLE : DATA;
        end
        DATA: begin
          if (expire) begin
            sreg_q    <= {sample, sreg_q[8:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == nsamp - 4'd1) state_q <= STOP;
          end
        end
        STOP: begin
          if (expire) begin
            data       <= dbits;
            perr       <= par_err;
            ferr       <= ~sample;
            ovf        <= rxrdy & ~read;
            rxrdy      <= 1'b1;
            // A low stop bit may be a break; hold off until the line goes idle.
            brk_wait_q <= ~sample;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_engine.sv
// Self-checking bench for rx_engine: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_rx_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [3:0] baud;
  logic       eight, p_en, ohel, read;
  logic [7:0] data;
  logic       rxrdy, perr, ferr, ovf;

  rx_engine #(
    .SYNC_STAGES (2),
    .CLK_HZ      (100000000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .baud  (baud),
    .eight (eight),
    .p_en  (p_en),
    .ohel  (ohel),
    .read  (read),
    .data  (data),
    .rxrdy (rxrdy),
    .perr  (perr),
    .ferr  (ferr),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_data;
  logic       exp_rxrdy, exp_perr, exp_ferr, exp_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".data"},  32'(data),  32'(exp_data));
    check_eq({tag, ".rxrdy"}, 32'(rxrdy), 32'(exp_rxrdy));
    check_eq({tag, ".perr"},  32'(perr),  32'(exp_perr));
    check_eq({tag, ".ferr"},  32'(ferr),  32'(exp_ferr));
    check_eq({tag, ".ovf"},   32'(ovf),   32'(exp_ovf));
  endtask

  function automatic int bit_clocks(input logic [3:0] b);
    int rate;
    case (b)
      4'h0: rate = 300;    4'h1: rate = 1200;   4'h2: rate = 2400;   4'h3: rate = 4800;
      4'h4: rate = 9600;   4'h5: rate = 19200;  4'h6: rate = 38400;  4'h7: rate = 57600;
      4'h8: rate = 115200; 4'h9: rate = 230400; 4'hA: rate = 460800; 4'hB: rate = 921600;
      default: rate = 115200;
    endcase
    return 100000000 / rate;
  endfunction

  function automatic logic [7:0] mask7(input logic e8, input logic [7:0] d);
    return e8 ? d : {1'b0, d[6:0]};
  endfunction

  // Reference: what the processor should see after one completed frame.
  task automatic model_frame(input logic e8, input logic pe, input logic odd,
                             input logic [7:0] dat, input logic pbit, input logic stop_v,
                             input logic rd);
    logic [7:0] d;
    int ones;
    d    = mask7(e8, dat);
    ones = $countones(d);
    exp_ovf   = exp_rxrdy & ~rd;
    exp_rxrdy = 1'b1;
    exp_data  = d;
    exp_perr  = pe & (pbit != ((ones % 2 == 1) ^ odd));
    exp_ferr  = ~stop_v;
  endtask

  task automatic do_read();
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    exp_rxrdy = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame, N clocks per bit. upd is the clock edge (counted from the
  // start-bit drive) at which the result should land in the output registers.
  task automatic send_frame(input logic [3:0] b, input logic e8, input logic pe,
                            input logic odd, input logic [7:0] dat, input logic flip,
                            input logic stop_v, input logic rd_upd, input logic scramble,
                            input int glitch_bit);
    int n, h, nb, upd, len, g, idx;
    logic [10:0] line;
    logic [7:0]  d;
    logic        pbit, prev_rdy;
    rx = 1'b1; baud = b; eight = e8; p_en = pe; ohel = odd;
    idle(4);
    n    = bit_clocks(b);
    h    = n / 2;
    nb   = (e8 ? 8 : 7) + (pe ? 1 : 0);
    upd  = h + 4 + (n + 1) * (nb + 1);
    len  = n * (nb + 2);
    g    = h + 2 + (n + 1) * (glitch_bit + 1);
    d    = mask7(e8, dat);
    pbit = (($countones(d) % 2) == 1) ^ odd ^ flip;
    line = '1;
    line[0] = 1'b0;
    for (int i = 0; i < (e8 ? 8 : 7); i++) line[1 + i] = d[i];
    if (pe) line[1 + (e8 ? 8 : 7)] = pbit;
    line[nb + 1] = stop_v;
    prev_rdy = exp_rxrdy;
    rx = line[0];
    for (int c = 1; c <= len; c++) begin
      @(posedge clk); #1;
      idx = c / n;
      rx  = (idx <= nb + 1) ? line[idx] : 1'b1;
      if (glitch_bit >= 0 && c >= g - 2 && c <= g + 1) rx = 1'b1;
      if (scramble && c == h + 10) begin
        baud = 4'($urandom); eight = 1'($urandom); p_en = 1'($urandom); ohel = 1'($urandom);
      end
      read = 1'b0;
      if (c == upd - 1) begin
        check_eq("rdy_early", 32'(rxrdy), 32'(prev_rdy));
        if (rd_upd) read = 1'b1;
      end
      if (c == upd) check_eq("rdy_edge", 32'(rxrdy), 32'd1);
    end
    read = 1'b0;
    model_frame(e8, pe, odd, dat, pbit, stop_v, rd_upd);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rb;
    rst = 1'b0; rx = 1'b1; baud = 4'h8; eight = 1'b1; p_en = 1'b0; ohel = 1'b0; read = 1'b0;
    exp_data = '0; exp_rxrdy = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovf = 1'b0;
    idle(3);
    check_outputs("reset");
    rst = 1'b1;
    idle(3);

    // 0xA5, 8N1 at 115200.
    send_frame(4'h8, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    check_outputs("a5");
    do_read();
    check_outputs("a5_read");

    // 7 bits, odd parity: correct then wrong parity bit.
    send_frame(4'hB, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    check_outputs("par_ok");
    do_read();
    send_frame(4'hB, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    check_outputs("par_bad");
    do_read();

    // Bit 7 of the byte must not leak through in 7-bit mode.
    send_frame(4'hA, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    check_outputs("seven_bit");
    do_read();

    // Framing error, then read clears.
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    check_outputs("ferr");
    do_read();
    check_outputs("ferr_read");

    // Overrun, then a read landing on the second update.
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    check_outputs("ovf");
    do_read();
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    check_outputs("ovf_read_coinc");
    do_read();

    // Read while nothing is pending.
    do_read();
    check_outputs("idle_read");

    // Short low glitch is a false start.
    baud = 4'h8; rx = 1'b0;
    idle(300);
    rx = 1'b1;
    idle(1200);
    check_outputs("false_start");

    // Break: exactly one all-zero frame with ferr, no repeats while held low.
    baud = 4'hB; eight = 1'b1; p_en = 1'b0; ohel = 1'b0;
    idle(4);
    rx = 1'b0;
    idle(108 * 12);
    exp_data = 8'h00; exp_rxrdy = 1'b1; exp_ferr = 1'b1; exp_perr = 1'b0; exp_ovf = 1'b0;
    check_outputs("break");
    do_read();
    idle(108 * 30);
    check_outputs("break_hold");
    rx = 1'b1;
    idle(10);

    // High glitch centred on data bit 3 of 0x00.
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3);
`ifndef RX_MAJORITY_EN
    exp_data = 8'h08;
`endif
    check_outputs("data_glitch");
    do_read();

    // Reset mid-frame with an unread byte pending.
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    rx = 1'b0;
    idle(300);
    rst = 1'b0;
    #1;
    exp_data = '0; exp_rxrdy = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovf = 1'b0;
    check_outputs("async_reset");
    rx = 1'b1;
    idle(5);
    rst = 1'b1;
    idle(2);
    send_frame(4'hB, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    check_outputs("after_reset");
    do_read();

    // Randomized frames; inputs are scrambled mid-frame to exercise shadowing.
    for (int k = 0; k < 16; k++) begin
      rb = ($urandom % 2 == 0) ? 4'hA : 4'hB;
      send_frame(rb, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                 ($urandom % 4 == 0), ($urandom % 6 != 0), ($urandom % 5 == 0), 1'b1, -1);
      check_outputs("rand");
      if ($urandom % 2 == 0) begin
        do_read();
        check_outputs("rand_read");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
